// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the multicycle RV32I control path.
// Holds the controller state enum, the supported opcodes, the ALUOp and
// ALUControl encodings, the multiplexer select encodings and a small helper
// that tells whether an opcode is one the controller knows how to sequence.
package riscv_pkg;

  // Controller states, one per step of the shared datapath
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  // Supported opcodes (Instr[6:0])
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALUOp: what the ALU decoder is asked to produce
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ImmSrc encodings
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // True for every opcode the controller can execute
  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: legal = 1'b1;
      default:                                  legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: turns ALUOp plus the instruction function fields into the
// ALU operation select. Purely combinational; also used by the single-cycle
// core.
// Ports:
//   alu_op_i      ALUOp from the main controller (00 add, 01 sub, 10 funct)
//   funct3_i      Instr[14:12]
//   op5_i         Instr[5], separates R-type from I-type
//   funct7b5_i    Instr[30]
//   alu_control_o ALU operation select
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  // ALU operation select from ALUOp and function fields
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000: begin
            // addi never subtracts, even when its immediate sets bit 30
            if (op5_i & funct7b5_i) begin
              alu_control_o = ALU_SUB;
            end else begin
              alu_control_o = ALU_ADD;
            end
          end
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle RV32I core.
// Steps the shared datapath through fetch, decode and execute for lw, sw,
// R-type, I-type ALU, beq and jal, and counts retired instructions.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   op, funct3,
//   funct7b5          instruction fields from IR
//   Zero              ALU zero flag (used combinationally in BEQ)
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegWrite   datapath controls
//   Illegal           one-cycle pulse in DECODE for an unsupported opcode
//   InstRet           retired-instruction counter
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstRet
);

  state_e           state_q;
  state_e           state_d;
  state_e           dec_state_s;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;
  logic             retire_s;
  logic             pc_update_s;
  logic             branch_s;
  logic             ir_write_s;
  logic             mem_write_s;
  logic             reg_write_s;
  logic [1:0]       alu_op_s;

  // Next-state selection
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op[5]) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // An instruction retires in its last state; illegal ones never get there
  always_comb begin
    case (state_q)
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: retire_s = 1'b1;
      default:                             retire_s = 1'b0;
    endcase
    if (retire_s) begin
      instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_d = instret_q;
    end
  end

  // State and retired-instruction counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Moore control decode; during reset the FETCH decode is shown so the
  // datapath muxes sit in a known position
  always_comb begin
    if (reset) begin
      dec_state_s = state_q;
    end else begin
      dec_state_s = S_FETCH;
    end
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RD2;
    alu_op_s    = ALUOP_ADD;
    case (dec_state_s)
      S_FETCH: begin
        ir_write_s  = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        pc_update_s = 1'b1;
      end
      S_DECODE: begin
        // OldPC + ImmExt: branch target held in ALUOut for BEQ
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA  = SRCA_RD1;
        alu_op_s = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_IMM;
        alu_op_s = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = SRCA_RD1;
        alu_op_s = ALUOP_SUB;
        branch_s = 1'b1;
      end
      S_JAL: begin
        // OldPC + 4 is the link value; PC takes the target from ALUOut
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        pc_update_s = 1'b1;
      end
      default: begin
        pc_update_s = 1'b0;
      end
    endcase
  end

  // Immediate format follows the opcode alone
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op_s),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (ALUControl)
  );

  // Write strobes are held off while reset is low
  assign PCWrite  = reset & (pc_update_s | (branch_s & Zero));
  assign IRWrite  = reset & ir_write_s;
  assign MemWrite = reset & mem_write_s;
  assign RegWrite = reset & reg_write_s;
  assign Illegal  = reset & (state_q == S_DECODE) & ~is_legal_op(op);
  assign InstRet  = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller.
// Each instruction pushes one expected control vector per cycle; a monitor
// on the falling edge pops and compares against the DUT.
module tb_multicycle_controller;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_BAD = 7'b1111111;

  typedef enum int {
    X_FETCH, X_DECODE, X_MEMADR, X_MEMREAD, X_MEMWB, X_MEMWRITE,
    X_EXECR, X_EXECI, X_ALUWB, X_BEQ, X_JAL, X_RESET
  } tst_e;

  typedef struct {
    tst_e        st;
    logic [48:0] vec;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        Zero;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] InstRet;

  exp_t        sb_q[$];
  exp_t        cur_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = 32'd0;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .Illegal(Illegal), .InstRet(InstRet)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [6:0] o);
    return (o == T_LW) || (o == T_SW) || (o == T_R) || (o == T_I) ||
           (o == T_BEQ) || (o == T_JAL);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegWrite,Illegal}
  function automatic logic [16:0] ctrl_exp(input tst_e st, input logic [6:0] o,
                                           input logic [2:0] f3, input logic f7, input logic z);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ill = 1'b0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
    case (o)
      T_SW:    imm = 2'b01;
      T_BEQ:   imm = 2'b10;
      T_JAL:   imm = 2'b11;
      default: imm = 2'b00;
    endcase
    case (st)
      X_FETCH:    begin pcw = 1'b1; irw = 1'b1; rs = 2'b10; sb = 2'b10; end
      X_RESET:    begin rs = 2'b10; sb = 2'b10; end
      X_DECODE:   begin sa = 2'b01; sb = 2'b01; ill = !is_legal(o); end
      X_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      X_MEMREAD:  begin adr = 1'b1; end
      X_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
      X_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      X_EXECR:    begin sa = 2'b10; alu = funct_alu(o, f3, f7); end
      X_EXECI:    begin sa = 2'b10; sb = 2'b01; alu = funct_alu(o, f3, f7); end
      X_ALUWB:    begin rw = 1'b1; end
      X_BEQ:      begin sa = 2'b10; alu = 3'b001; pcw = z; end
      X_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      default:    begin pcw = 1'b0; end
    endcase
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill};
  endfunction

  task automatic push_exp(input tst_e st, input logic [31:0] ret);
    exp_t e;
    e.st  = st;
    e.vec = {ret, ctrl_exp(st, op, funct3, funct7b5, Zero)};
    sb_q.push_back(e);
  endtask

  // Run one instruction starting in FETCH, just after a rising edge
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    tst_e sts[$];
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    case (o)
      T_LW:    sts = '{X_FETCH, X_DECODE, X_MEMADR, X_MEMREAD, X_MEMWB};
      T_SW:    sts = '{X_FETCH, X_DECODE, X_MEMADR, X_MEMWRITE};
      T_R:     sts = '{X_FETCH, X_DECODE, X_EXECR, X_ALUWB};
      T_I:     sts = '{X_FETCH, X_DECODE, X_EXECI, X_ALUWB};
      T_BEQ:   sts = '{X_FETCH, X_DECODE, X_BEQ};
      T_JAL:   sts = '{X_FETCH, X_DECODE, X_JAL, X_ALUWB};
      default: sts = '{X_FETCH, X_DECODE};
    endcase
    foreach (sts[i]) push_exp(sts[i], exp_ret);
    repeat (sts.size()) @(posedge clk);
    #1;
    if (is_legal(o)) exp_ret = exp_ret + 32'd1;
  endtask

  // Compare DUT outputs against the scoreboard on the falling edge
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur_e = sb_q.pop_front();
      check_val(cur_e.st.name(),
                {15'd0, InstRet, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ALUControl, ImmSrc, RegWrite, Illegal},
                {15'd0, cur_e.vec});
    end
  end

  initial begin
    reset = 1'b0; op = T_LW; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    push_exp(X_RESET, 32'd0);
    push_exp(X_RESET, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    run_instr(T_LW,  3'b000, 1'b0, 1'b0);
    run_instr(T_SW,  3'b010, 1'b0, 1'b0);
    run_instr(T_R,   3'b000, 1'b0, 1'b0);
    run_instr(T_R,   3'b000, 1'b1, 1'b0);
    run_instr(T_R,   3'b111, 1'b1, 1'b0);
    run_instr(T_R,   3'b010, 1'b0, 1'b0);
    run_instr(T_R,   3'b110, 1'b0, 1'b0);
    run_instr(T_I,   3'b000, 1'b1, 1'b0);
    run_instr(T_I,   3'b001, 1'b0, 1'b0);
    run_instr(T_BEQ, 3'b000, 1'b0, 1'b1);
    run_instr(T_BEQ, 3'b000, 1'b0, 1'b0);
    run_instr(T_JAL, 3'b000, 1'b0, 1'b0);
    run_instr(T_BAD, 3'b000, 1'b0, 1'b0);
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0);

    // sw aborted by reset while in MEMWRITE
    op = T_SW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    push_exp(X_FETCH, exp_ret);
    push_exp(X_DECODE, exp_ret);
    push_exp(X_MEMADR, exp_ret);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    push_exp(X_RESET, exp_ret);
    push_exp(X_RESET, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_ret = 32'd0;

    run_instr(T_LW,  3'b010, 1'b0, 1'b0);
    run_instr(T_JAL, 3'b000, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    check_val("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
